alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller that drives the 16-bit combinational ALU from the other side of its interface.
- Accepts operation commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives ALU operands, opcode and carry from registers, captures result and neg/zer flags, writes back, and returns a response via valid/ready.
- Sits between a command source (testbench or future instruction decoder) and the existing ALU instance.

Parameters:
- NREG, 4, number of 16-bit registers; power of 2, minimum 2.
- DW, 16, datapath width; fixed at 16 to match the ALU.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  operation; 000..110 are ALU opcodes, 111 is LOAD.
- cmd_dst  in  $clog2(NREG)  destination register index.
- cmd_srca  in  $clog2(NREG)  A operand register index.
- cmd_srcb  in  $clog2(NREG)  B operand register index.
- cmd_carry  in  1  carry-in, used by opcode 010.
- cmd_imm  in  DW  immediate for LOAD.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_op  out  3  ALU opcode.
- alu_carry  out  1  ALU carry-in.
- alu_w  in  DW  ALU result.
- alu_neg  in  1  ALU negative flag.
- alu_zer  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DW  value written to cmd_dst.
- rsp_neg  out  1  negative flag of rsp_data.
- rsp_zer  out  1  zero flag of rsp_data.
- err  out  1  sticky mismatch flag (ALU_CHECK_EN only).

Behaviour:
- Reset values: all registers 0; alu_a/alu_b/alu_op/alu_carry 0; rsp_* 0; err 0; state IDLE.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command. LOAD goes to RESP; all other ops go to ISSUE.
  - ISSUE: register alu_a=reg[srca], alu_b=reg[srcb], alu_op=op, alu_carry=cmd_carry. Go to CAPTURE.
  - CAPTURE: sample alu_w/alu_neg/alu_zer into rsp_data/rsp_neg/rsp_zer; write reg[dst]=alu_w. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE.
- cmd_ready is 1 only in IDLE; no pipelining of commands.
- LOAD: reg[dst]=cmd_imm at acceptance edge; rsp_data=cmd_imm; rsp_neg=cmd_imm[15]; rsp_zer=(cmd_imm==0). ALU ports are not changed.
- Latency from accept edge to rsp_valid high: LOAD 1 cycle; ALU ops 3 cycles.
- Operands are read from the register file in ISSUE, so the previous command's writeback is always visible (no hazard).
- srca==srcb==dst is legal; the write happens after the read.
- RESP holds all rsp_* stable until rsp_ready. rsp_ready while rsp_valid=0 is ignored.
- ALU outputs hold their last values outside ISSUE/CAPTURE.
- rst in any state: return to IDLE in the next cycle, clear register file and outputs, drop any in-flight command with no response.

Optional Feature:
- Macro: ALU_CHECK_EN.
- Defined: in CAPTURE, compute the expected result from alu_a/alu_b/alu_op/alu_carry:
  - 000 → ~A+1
  - 001 → A+1
  - 010 → A+B+carry
  - 011 → A+(B>>1), logical shift
  - 100 → A&B
  - 101 → A|B
  - 110 → {A[7:0],B[7:0]}
  - Any mismatch with alu_w, alu_neg or alu_zer sets err, which stays 1 until rst.
- Undefined: err tied 0; no checker logic.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_NEG=000, OP_INC=001, OP_ADC=010, OP_ADDH=011, OP_AND=100, OP_OR=101, OP_CAT=110, OP_LOAD=111;
  - state enum {IDLE, ISSUE, CAPTURE, RESP}.
- Sub-module alu_seq_regfile: NREG x DW, two combinational read ports, one synchronous write port, synchronous clear on rst.

Test Plan:
- LOAD r0=0x0005, LOAD r1=0x0003, then op 010 dst r2, srca r0, srcb r1, carry=1 → rsp_data 0x0009, neg 0, zer 0; rsp_valid exactly 3 cycles after accept.
- r0=0x0005, op 000 dst r3, srca r0 → rsp_data 0xFFFB, neg 1, zer 0; r3 reads back 0xFFFB.
- r0=0x1234, r1=0xABCD, op 110 → 0x34CD. Then r0=0x0010, r1=0x0006, op 011 → 0x0013.
- r0=0x00F0, r1=0x0F00, op 100 → rsp_data 0x0000, zer 1. Hold rsp_ready=0 for 5 cycles: rsp_* stable, cmd_ready 0 throughout.
- Assert rst during CAPTURE → next cycle IDLE, no rsp_valid, all registers 0, err 0.
- With ALU_CHECK_EN, force alu_w wrong by 1 on one ADC → err rises in the cycle after CAPTURE and stays 1 until rst.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, controller states and the ALU reference function
// shared by the alu_seq_ctrl slice.
package alu_seq_pkg;

    localparam logic [2:0] OP_NEG  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_ADC  = 3'b010;
    localparam logic [2:0] OP_ADDH = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_CAT  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    // Result the 16-bit ALU is expected to produce for a given operand set
    function automatic logic [15:0] alu_expect(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [2:0]  op,
        input logic        carry
    );
        logic [15:0] r;
        case (op)
            OP_NEG:  r = ~a + 16'd1;
            OP_INC:  r = a + 16'd1;
            OP_ADC:  r = a + b + {15'd0, carry};
            OP_ADDH: r = a + {1'b0, b[15:1]};
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_CAT:  r = {a[7:0], b[7:0]};
            default: r = 16'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x DW register file with two combinational read ports,
// one synchronous write port and a synchronous clear.
module alu_seq_regfile #(
    parameter int NREG = 4,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] rd_a_idx,
    input  logic [$clog2(NREG)-1:0] rd_b_idx,
    output logic [DW-1:0]           rd_a_data,
    output logic [DW-1:0]           rd_b_data,
    input  logic                    wr_en,
    input  logic [$clog2(NREG)-1:0] wr_idx,
    input  logic [DW-1:0]           wr_data
);

    logic [DW-1:0] mem_r [NREG];

    // Storage: clear on reset, otherwise single write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_a_data = mem_r[rd_a_idx];
    assign rd_b_data = mem_r[rd_b_idx];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command-driven sequencer that feeds the 16-bit ALU from a small
// register file. Define ALU_CHECK_EN to add the sticky ALU result checker (err).
module alu_seq_ctrl #(
    parameter int NREG = 4,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_dst,
    input  logic [$clog2(NREG)-1:0] cmd_srca,
    input  logic [$clog2(NREG)-1:0] cmd_srcb,
    input  logic                    cmd_carry,
    input  logic [DW-1:0]           cmd_imm,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [2:0]              alu_op,
    output logic                    alu_carry,
    input  logic [DW-1:0]           alu_w,
    input  logic                    alu_neg,
    input  logic                    alu_zer,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_data,
    output logic                    rsp_neg,
    output logic                    rsp_zer,
    output logic                    err
);
    import alu_seq_pkg::*;

    localparam int AW = $clog2(NREG);

    state_t        state_r;
    state_t        state_nxt_s;
    logic          accept_s;
    logic          load_s;
    logic [2:0]    op_r;
    logic [AW-1:0] dst_r;
    logic [AW-1:0] srca_r;
    logic [AW-1:0] srcb_r;
    logic          carry_r;
    logic [DW-1:0] rd_a_s;
    logic [DW-1:0] rd_b_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [DW-1:0] wr_data_s;
    logic          cmd_ready_r;
    logic          rsp_valid_r;
    logic [DW-1:0] rsp_data_r;
    logic          rsp_neg_r;
    logic          rsp_zer_r;
    logic [DW-1:0] alu_a_r;
    logic [DW-1:0] alu_b_r;
    logic [2:0]    alu_op_r;
    logic          alu_carry_r;

    alu_seq_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_a_idx  (srca_r),
        .rd_b_idx  (srcb_r),
        .rd_a_data (rd_a_s),
        .rd_b_data (rd_b_s),
        .wr_en     (wr_en_s),
        .wr_idx    (wr_idx_s),
        .wr_data   (wr_data_s)
    );

    // Next-state decode; a command is only taken in IDLE
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    load_s      = (cmd_op == OP_LOAD);
                    state_nxt_s = load_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE:   state_nxt_s = CAPTURE;
            CAPTURE: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Write port: LOAD writes at acceptance, ALU ops write back in CAPTURE
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = dst_r;
        wr_data_s = alu_w;
        if (load_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = cmd_dst;
            wr_data_s = cmd_imm;
        end else if (state_r == CAPTURE) begin
            wr_en_s   = 1'b1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // State register plus the handshake flags derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Latched command fields for the in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= 3'd0;
            dst_r   <= '0;
            srca_r  <= '0;
            srcb_r  <= '0;
            carry_r <= 1'b0;
        end else if (accept_s) begin
            op_r    <= cmd_op;
            dst_r   <= cmd_dst;
            srca_r  <= cmd_srca;
            srcb_r  <= cmd_srcb;
            carry_r <= cmd_carry;
        end
    end

    // ALU operand drive; holds its value outside ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_op_r    <= 3'd0;
            alu_carry_r <= 1'b0;
        end else if (state_r == ISSUE) begin
            alu_a_r     <= rd_a_s;
            alu_b_r     <= rd_b_s;
            alu_op_r    <= op_r;
            alu_carry_r <= carry_r;
        end
    end

    // Response payload; stays put through RESP until the next command fills it
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r <= '0;
            rsp_neg_r  <= 1'b0;
            rsp_zer_r  <= 1'b0;
        end else if (load_s) begin
            rsp_data_r <= cmd_imm;
            rsp_neg_r  <= cmd_imm[DW-1];
            rsp_zer_r  <= (cmd_imm == {DW{1'b0}});
        end else if (state_r == CAPTURE) begin
            rsp_data_r <= alu_w;
            rsp_neg_r  <= alu_neg;
            rsp_zer_r  <= alu_zer;
        end
    end

`ifdef ALU_CHECK_EN
    logic [DW-1:0] exp_w_s;
    logic          mismatch_s;
    logic          err_r;

    // Recompute the ALU result from the operands actually driven
    always_comb begin
        exp_w_s    = alu_expect(alu_a_r, alu_b_r, alu_op_r, alu_carry_r);
        mismatch_s = (exp_w_s != alu_w) ||
                     (exp_w_s[DW-1] != alu_neg) ||
                     ((exp_w_s == {DW{1'b0}}) != alu_zer);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == CAPTURE) && mismatch_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_neg   = rsp_neg_r;
    assign rsp_zer   = rsp_zer_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign alu_carry = alu_carry_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and randomized checks of alu_seq_ctrl against a
// register-level reference model; the bench also plays the combinational ALU.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
    localparam int NREG = 4;
    localparam int DW   = 16;
    localparam int AW   = $clog2(NREG);
`ifdef ALU_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic          cmd_carry;
    logic [DW-1:0] cmd_imm;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic          alu_carry;
    logic [DW-1:0] alu_w;
    logic          alu_neg;
    logic          alu_zer;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_neg;
    logic          rsp_zer;
    logic          err;

    logic          corrupt;
    logic [15:0]   mdl [NREG];
    logic [15:0]   exp_a;
    logic [15:0]   exp_b;
    logic [2:0]    exp_op;
    logic          exp_c;
    logic [15:0]   exp_data;
    logic [15:0]   obs_data;
    logic          obs_neg;
    logic          obs_zer;
    int            obs_lat;
    int            checks;
    int            failures;

    alu_seq_ctrl #(.NREG(NREG), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_carry (cmd_carry),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_carry (alu_carry),
        .alu_w     (alu_w),
        .alu_neg   (alu_neg),
        .alu_zer   (alu_zer),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_neg   (rsp_neg),
        .rsp_zer   (rsp_zer),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ALU behaviour written as plain arithmetic
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return 16'd0 - a;
            3'd1:    return a + 16'd1;
            3'd2:    return a + b + 16'(c);
            3'd3:    return a + b / 16'd2;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return (a % 16'd256) * 16'd256 + (b % 16'd256);
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        alu_w   = ref_alu(alu_op, alu_a, alu_b, alu_carry) + (corrupt ? 16'd1 : 16'd0);
        alu_neg = alu_w[15];
        alu_zer = (alu_w == 16'd0);
    end

    task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                               input logic [AW-1:0] sb, input logic c, input logic [15:0] imm);
        if (op == 3'd7) begin
            exp_data = imm;
        end else begin
            exp_data = ref_alu(op, mdl[sa], mdl[sb], c);
            exp_a = mdl[sa]; exp_b = mdl[sb]; exp_op = op; exp_c = c;
        end
        mdl[dst] = exp_data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) mdl[i] = 16'd0;
        exp_a = 16'd0; exp_b = 16'd0; exp_op = 3'd0; exp_c = 1'b0;
    endtask

    // Present a command, wait for acceptance, then wait for rsp_valid (bounded)
    task automatic issue_cmd(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                             input logic [AW-1:0] sb, input logic c, input logic [15:0] imm);
        int waitc;
        cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_carry = c; cmd_imm = imm;
        cmd_valid = 1'b1;
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        obs_lat = 1;
        while (!rsp_valid && obs_lat < 20) begin @(posedge clk); #1; obs_lat++; end
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
        obs_data = rsp_data; obs_neg = rsp_neg; obs_zer = rsp_zer;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                           input logic [AW-1:0] sb, input logic c, input logic [15:0] imm);
        model_apply(op, dst, sa, sb, c, imm);
        issue_cmd(op, dst, sa, sb, c, imm);
        finish_rsp();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; corrupt = 1'b0;
        cmd_op = 3'd0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_carry = 1'b0; cmd_imm = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op, alu_carry} !== '0) begin failures++;
            $display("FAIL reset_alu_ports: got %h %h %h %b want zeros", alu_a, alu_b, alu_op, alu_carry); end
        checks++; if ({rsp_data, rsp_neg, rsp_zer} !== '0) begin failures++;
            $display("FAIL reset_rsp: got %h %b %b want zeros", rsp_data, rsp_neg, rsp_zer); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        for (int i = 0; i < NREG; i++) begin
            run_cmd(3'd5, AW'(i), AW'(i), AW'(i), 1'b0, 16'd0);
            checks++; if (obs_data !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d: got %h want 0000", i, obs_data); end
        end
    endtask

    task automatic test_adc();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0005);
        checks++; if (obs_lat !== 1) begin failures++; $display("FAIL load_latency: got %0d want 1", obs_lat); end
        checks++; if ({obs_data, obs_neg, obs_zer} !== {16'h0005, 2'b00}) begin failures++;
            $display("FAIL load_rsp: got %h %b %b want 0005 0 0", obs_data, obs_neg, obs_zer); end
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0003);
        run_cmd(3'd2, 2'd2, 2'd0, 2'd1, 1'b1, 16'h0000);
        checks++; if ({obs_data, obs_neg, obs_zer} !== {16'h0009, 2'b00}) begin failures++;
            $display("FAIL adc_rsp: got %h %b %b want 0009 0 0", obs_data, obs_neg, obs_zer); end
        checks++; if (obs_lat !== 3) begin failures++; $display("FAIL adc_latency: got %0d want 3", obs_lat); end
        checks++; if ({alu_a, alu_b, alu_op, alu_carry} !== {16'h0005, 16'h0003, 3'd2, 1'b1}) begin failures++;
            $display("FAIL adc_alu_ports: got %h %h %h %b want 0005 0003 2 1", alu_a, alu_b, alu_op, alu_carry); end
    endtask

    task automatic test_neg();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0005);
        checks++; if ({alu_a, alu_b, alu_op, alu_carry} !== {16'h0005, 16'h0003, 3'd2, 1'b1}) begin failures++;
            $display("FAIL load_alu_hold: got %h %h %h %b want 0005 0003 2 1", alu_a, alu_b, alu_op, alu_carry); end
        run_cmd(3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0000);
        checks++; if ({obs_data, obs_neg, obs_zer} !== {16'hFFFB, 2'b10}) begin failures++;
            $display("FAIL neg_rsp: got %h %b %b want fffb 1 0", obs_data, obs_neg, obs_zer); end
        run_cmd(3'd5, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0000);
        checks++; if (obs_data !== 16'hFFFB) begin failures++; $display("FAIL neg_readback: got %h want fffb", obs_data); end
    endtask

    task automatic test_cat_addh();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h1234);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'hABCD);
        run_cmd(3'd6, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        checks++; if (obs_data !== 16'h34CD) begin failures++; $display("FAIL cat_rsp: got %h want 34cd", obs_data); end
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0010);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0006);
        run_cmd(3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        checks++; if (obs_data !== 16'h0013) begin failures++; $display("FAIL addh_rsp: got %h want 0013", obs_data); end
    endtask

    task automatic test_and_hold();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h00F0);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0F00);
        model_apply(3'd4, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        issue_cmd(3'd4, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        checks++; if ({obs_data, obs_neg, obs_zer} !== {16'h0000, 2'b01}) begin failures++;
            $display("FAIL and_rsp: got %h %b %b want 0000 0 1", obs_data, obs_neg, obs_zer); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_neg, rsp_zer, cmd_ready} !== {1'b1, 16'h0000, 2'b01, 1'b0}) begin failures++;
                $display("FAIL hold_stable[%0d]: got v=%b d=%h n=%b z=%b rdy=%b want 1 0000 0 1 0",
                         k, rsp_valid, rsp_data, rsp_neg, rsp_zer, cmd_ready); end
        end
        finish_rsp();
        checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++;
            $display("FAIL rsp_release: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [AW-1:0] dst, sa, sb;
        logic          c;
        logic [15:0]   imm;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            dst = AW'($urandom_range(0, NREG - 1));
            sa  = AW'($urandom_range(0, NREG - 1));
            sb  = AW'($urandom_range(0, NREG - 1));
            c   = 1'($urandom_range(0, 1));
            imm = (n % 7 == 0) ? 16'd0 : 16'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            model_apply(op, dst, sa, sb, c, imm);
            issue_cmd(op, dst, sa, sb, c, imm);
            checks++;
            if ({obs_data, obs_neg, obs_zer} !== {exp_data, exp_data[15], exp_data == 16'd0}) begin failures++;
                $display("FAIL rand_rsp[%0d] op=%0d: got %h %b %b want %h %b %b", n, op, obs_data, obs_neg, obs_zer,
                         exp_data, exp_data[15], exp_data == 16'd0); end
            checks++;
            if (obs_lat !== ((op == 3'd7) ? 1 : 3)) begin failures++;
                $display("FAIL rand_latency[%0d] op=%0d: got %0d", n, op, obs_lat); end
            checks++;
            if ({alu_a, alu_b, alu_op, alu_carry} !== {exp_a, exp_b, exp_op, exp_c}) begin failures++;
                $display("FAIL rand_alu_ports[%0d]: got %h %h %h %b want %h %h %h %b", n, alu_a, alu_b, alu_op,
                         alu_carry, exp_a, exp_b, exp_op, exp_c); end
            finish_rsp();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_capture();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h1111);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h2222);
        cmd_op = 3'd2; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_carry = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (alu_a !== 16'h1111) begin failures++; $display("FAIL capture_operand: got %h want 1111", alu_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        checks++; if ({cmd_ready, rsp_valid, err} !== 3'b100) begin failures++;
            $display("FAIL rst_capture_state: got rdy=%b v=%b err=%b want 1 0 0", cmd_ready, rsp_valid, err); end
        checks++; if ({alu_a, alu_b, alu_op, alu_carry, rsp_data} !== '0) begin failures++;
            $display("FAIL rst_capture_outputs: got %h %h %h %b %h want zeros", alu_a, alu_b, alu_op, alu_carry, rsp_data); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_rsp[%0d]: got %b want 0", k, rsp_valid); end
        end
        for (int i = 0; i < NREG; i++) begin
            run_cmd(3'd5, AW'(i), AW'(i), AW'(i), 1'b0, 16'd0);
            checks++; if (obs_data !== 16'h0000) begin failures++; $display("FAIL rst_capture_reg%0d: got %h want 0000", i, obs_data); end
        end
    endtask

    task automatic test_err();
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0100);
        run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0020);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_before: got %b want 0", err); end
        model_apply(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        mdl[2] = exp_data + 16'd1;
        corrupt = 1'b1;
        issue_cmd(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000);
        checks++; if (obs_data !== 16'h0121) begin failures++; $display("FAIL err_capture_data: got %h want 0121", obs_data); end
        checks++; if (err !== CHK_EN) begin failures++; $display("FAIL err_raise: got %b want %b", err, CHK_EN); end
        finish_rsp();
        corrupt = 1'b0;
        run_cmd(3'd5, 2'd3, 2'd2, 2'd2, 1'b0, 16'h0000);
        checks++; if (obs_data !== 16'h0121) begin failures++; $display("FAIL err_wb: got %h want 0121", obs_data); end
        checks++; if (err !== CHK_EN) begin failures++; $display("FAIL err_sticky: got %b want %b", err, CHK_EN); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_adc();
        test_neg();
        test_cat_addh();
        test_and_hold();
        test_random();
        test_reset_capture();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
